// File: rtl/coin_pkg.sv
// Shared types and constants for the coin payout path: FSM state encoding,
// coin face values and the unit-amount type (one unit = 5 rupees).
package coin_pkg;

  localparam int unsigned UNIT_W        = 6;
  localparam int unsigned COIN_FIVE_VAL = 5;
  localparam int unsigned COIN_TEN_VAL  = 10;

  typedef logic [UNIT_W-1:0] unit_amt_t;

  typedef enum logic [2:0] {
    StIdle,
    StCheck,
    StTen,
    StFive,
    StGap,
    StFin
  } coin_state_e;

endpackage

// File: rtl/coin_inventory.sv
// Two saturating up/down coin counters: +1 on refill, -1 on a dispense strobe.
module coin_inventory #(
  parameter int unsigned CNT_W     = 6,
  parameter int unsigned INIT_FIVE = 8,
  parameter int unsigned INIT_TEN  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             refill_five,
  input  logic             refill_ten,
  input  logic             dispense_five,
  input  logic             dispense_ten,
  output logic [CNT_W-1:0] five_count,
  output logic [CNT_W-1:0] ten_count
);

  localparam logic [CNT_W-1:0] CntMax = '1;

  logic [CNT_W-1:0] five_q, ten_q;

  // A refill and a dispense in the same cycle cancel; a refill at the ceiling is dropped.
  function automatic logic [CNT_W-1:0] next_cnt(logic [CNT_W-1:0] cnt, logic inc, logic dec);
    logic [CNT_W-1:0] res;
    res = cnt;
    case ({inc, dec})
      2'b10:   res = (cnt == CntMax) ? cnt : cnt + CNT_W'(1);
      2'b01:   res = cnt - CNT_W'(1);
      default: res = cnt;
    endcase
    return res;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      five_q <= CNT_W'(INIT_FIVE);
      ten_q  <= CNT_W'(INIT_TEN);
    end else begin
      five_q <= next_cnt(five_q, refill_five, dispense_five);
      ten_q  <= next_cnt(ten_q, refill_ten, dispense_ten);
    end
  end

  assign five_count = five_q;
  assign ten_count  = ten_q;

  a_no_five_underflow: assert property (@(posedge clk) disable iff (!rst_n)
    dispense_five |-> (five_q != '0));
  a_no_ten_underflow: assert property (@(posedge clk) disable iff (!rst_n)
    dispense_ten |-> (ten_q != '0));

endmodule

// File: rtl/coin_dispenser.sv
// Coin payout FSM: checks a request against inventory, then pulses tens, then fives.
// Define COIN_DISP_TRACE_EN for a simulation-only trace of every coin pulse and done.
module coin_dispenser #(
  parameter int unsigned AMT_W     = 6,
  parameter int unsigned CNT_W     = 6,
  parameter int unsigned INIT_FIVE = 8,
  parameter int unsigned INIT_TEN  = 8,
  parameter int unsigned PULSE_GAP = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  input  logic [AMT_W-1:0] req_amount,
  output logic             req_ready,
  input  logic             refill_five,
  input  logic             refill_ten,
  output logic             five_coin,
  output logic             ten_coin,
  output logic             busy,
  output logic             done,
  output logic             short,
  output logic [CNT_W-1:0] five_count,
  output logic [CNT_W-1:0] ten_count
);
  import coin_pkg::*;

  localparam int unsigned FW = AMT_W + 1;
  localparam int unsigned W  = (FW > CNT_W) ? FW : CNT_W;
  localparam logic [2:0] GapLast = 3'(PULSE_GAP - 1);

  coin_state_e      state_q, state_d;
  logic [AMT_W-1:0] amount_q, amount_d;
  logic [AMT_W-1:0] ten_rem_q, ten_rem_d;
  logic [FW-1:0]    five_rem_q, five_rem_d;
  logic [2:0]       gap_q, gap_d;
  logic             short_flag_q, short_flag_d;

  // Plan arithmetic at a common width so no comparison truncates.
  logic [W-1:0] half_w, ten_w, five_w, need_ten_w, need_five_w;
  assign half_w      = W'(amount_q >> 1);
  assign ten_w       = W'(ten_count);
  assign five_w      = W'(five_count);
  assign need_ten_w  = (half_w < ten_w) ? half_w : ten_w;
  assign need_five_w = W'(amount_q) - (need_ten_w << 1);

  function automatic coin_state_e next_coin(logic [AMT_W-1:0] tens, logic [FW-1:0] fives);
    if (tens != '0)  return StTen;
    if (fives != '0) return StFive;
    return StFin;
  endfunction

  always_comb begin
    state_d      = state_q;
    amount_d     = amount_q;
    ten_rem_d    = ten_rem_q;
    five_rem_d   = five_rem_q;
    gap_d        = gap_q;
    short_flag_d = short_flag_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          amount_d     = req_amount;
          short_flag_d = 1'b0;
          state_d      = StCheck;
        end
      end
      StCheck: begin
        if (need_five_w > five_w) begin
          short_flag_d = 1'b1;
          state_d      = StFin;
        end else if (amount_q == '0) begin
          state_d = StFin;
        end else begin
          ten_rem_d  = AMT_W'(need_ten_w);
          five_rem_d = FW'(need_five_w);
          state_d    = (need_ten_w != '0) ? StTen : StFive;
        end
      end
      StTen, StFive: begin
        if (state_q == StTen) ten_rem_d = ten_rem_q - AMT_W'(1);
        else                  five_rem_d = five_rem_q - FW'(1);
        if (PULSE_GAP != 0) begin
          gap_d   = GapLast;
          state_d = StGap;
        end else begin
          state_d = next_coin(ten_rem_d, five_rem_d);
        end
      end
      StGap: begin
        if (gap_q == '0) state_d = next_coin(ten_rem_q, five_rem_q);
        else             gap_d   = gap_q - 3'd1;
      end
      StFin:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs are decoded from the next state so each one comes straight off a flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      amount_q     <= '0;
      ten_rem_q    <= '0;
      five_rem_q   <= '0;
      gap_q        <= '0;
      short_flag_q <= 1'b0;
      ten_coin     <= 1'b0;
      five_coin    <= 1'b0;
      done         <= 1'b0;
      short        <= 1'b0;
      busy         <= 1'b0;
      req_ready    <= 1'b1;
    end else begin
      state_q      <= state_d;
      amount_q     <= amount_d;
      ten_rem_q    <= ten_rem_d;
      five_rem_q   <= five_rem_d;
      gap_q        <= gap_d;
      short_flag_q <= short_flag_d;
      ten_coin     <= (state_d == StTen);
      five_coin    <= (state_d == StFive);
      done         <= (state_d == StFin);
      short        <= (state_d == StFin) && short_flag_d;
      busy         <= (state_d != StIdle);
      req_ready    <= (state_d == StIdle);
    end
  end

  coin_inventory #(
    .CNT_W    (CNT_W),
    .INIT_FIVE(INIT_FIVE),
    .INIT_TEN (INIT_TEN)
  ) u_inventory (
    .clk          (clk),
    .rst_n        (rst_n),
    .refill_five  (refill_five),
    .refill_ten   (refill_ten),
    .dispense_five(five_coin),
    .dispense_ten (ten_coin),
    .five_count   (five_count),
    .ten_count    (ten_count)
  );

`ifdef COIN_DISP_TRACE_EN
  always_ff @(posedge clk) begin
    if (ten_coin)
      $display("%0t coin %0d tens_left %0d short %0b", $time, COIN_TEN_VAL,
               ten_rem_q - AMT_W'(1), short);
    if (five_coin)
      $display("%0t coin %0d fives_left %0d short %0b", $time, COIN_FIVE_VAL,
               five_rem_q - FW'(1), short);
    if (done)
      $display("%0t done tens_left %0d fives_left %0d short %0b", $time, ten_rem_q,
               five_rem_q, short);
  end
`else
  // Trace disabled: nothing extra is compiled.
`endif

endmodule
